// File: rtl/ice51_pkg.sv
// Shared types and helpers for the ice51 UART boot loader.
package ice51_pkg;

    // UART receiver frame states
    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    // Loader progress states
    typedef enum logic [1:0] {
        LD_IMAGE = 2'd0,
        LD_SUM   = 2'd1,
        LD_DONE  = 2'd2
    } ld_state_t;

    // Clock cycles per UART bit (integer division)
    function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned baud);
        return clk_hz / baud;
    endfunction

    // Ceiling log2, returns 0 for v <= 1
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (longint unsigned x = 1; x < longint'(v); x = x << 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ice51_uart_rx.sv
// UART 8N1 receiver: input synchroniser, frame FSM and drift-free bit timer.
module ice51_uart_rx
    import ice51_pkg::*;
#(
    parameter int unsigned DIV = 104
) (
    input  logic       i_clk,
    input  logic       i_nrst,
    input  logic       i_uart_rx,
    output logic [7:0] o_byte,
    output logic       o_valid,
    output logic       o_ferr
);

    localparam int unsigned TMR_W = clog2(DIV) + 1;
    localparam logic [TMR_W-1:0] HALF = TMR_W'(DIV / 2 - 1);
    localparam logic [TMR_W-1:0] FULL = TMR_W'(DIV - 1);

    logic             rx_meta, rx_sync, rx_prev;
    rx_state_t        state, state_d;
    logic [TMR_W-1:0] tmr, tmr_d;
    logic [2:0]       bit_idx, bit_idx_d;
    logic [7:0]       byte_d;
    logic             valid_d, ferr_d;
    logic             tmr_zero;

    // Two-flop synchroniser plus one delay flop for falling-edge detection
    always_ff @(posedge i_clk or posedge i_nrst) begin
        if (i_nrst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= i_uart_rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // Frame state register and datapath registers
    always_ff @(posedge i_clk or posedge i_nrst) begin
        if (i_nrst) begin
            state   <= RX_IDLE;
            tmr     <= '0;
            bit_idx <= '0;
            o_byte  <= '0;
            o_valid <= 1'b0;
            o_ferr  <= 1'b0;
        end else begin
            state   <= state_d;
            tmr     <= tmr_d;
            bit_idx <= bit_idx_d;
            o_byte  <= byte_d;
            o_valid <= valid_d;
            o_ferr  <= ferr_d;
        end
    end

    assign tmr_zero = (tmr == '0);

    // Next state; timer reloads at every sample point so error never accumulates
    always_comb begin
        state_d   = state;
        tmr_d     = tmr;
        bit_idx_d = bit_idx;
        byte_d    = o_byte;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
        case (state)
            RX_IDLE: begin
                if (rx_prev && !rx_sync) begin
                    tmr_d   = HALF;
                    state_d = RX_START;
                end
            end
            RX_START: begin
                if (tmr_zero) begin
                    tmr_d     = FULL;
                    bit_idx_d = '0;
                    state_d   = rx_sync ? RX_IDLE : RX_DATA;
                end else begin
                    tmr_d = tmr - TMR_W'(1);
                end
            end
            RX_DATA: begin
                if (tmr_zero) begin
                    tmr_d     = FULL;
                    byte_d    = {rx_sync, o_byte[7:1]};
                    bit_idx_d = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_d = RX_STOP;
                    end
                end else begin
                    tmr_d = tmr - TMR_W'(1);
                end
            end
            RX_STOP: begin
                if (tmr_zero) begin
                    state_d = RX_IDLE;
                    valid_d = rx_sync;
                    ferr_d  = !rx_sync;
                end else begin
                    tmr_d = tmr - TMR_W'(1);
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

endmodule

// File: rtl/ice51_uart_loader.sv
// Boot loader: streams a UART image into code memory and holds the core in reset until done.
module ice51_uart_loader
    import ice51_pkg::*;
#(
    parameter int unsigned CLK_HZ   = 12000000,
    parameter int unsigned BAUD     = 115200,
    parameter int unsigned MEM_SIZE = 512,
    parameter int unsigned ADDR_W   = 9,
    parameter int unsigned CHECKSUM = 0,
    parameter int unsigned PRELOAD  = 0
) (
    input  logic              i_clk,
    input  logic              i_nrst,
    input  logic              i_uart_rx,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [7:0]        o_mem_data,
    output logic              o_core_rst,
    output logic              o_done,
    output logic              o_err
);

    localparam int unsigned DIV   = calc_div(CLK_HZ, BAUD);
    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(MEM_SIZE - 1);

    logic              rx_line;
    logic [7:0]        rx_byte;
    logic              rx_valid, rx_ferr;

    ld_state_t         ld_state, ld_state_d;
    logic [CNT_W-1:0]  count, count_d;
    logic [7:0]        sum, sum_d;
    logic              we_d, done_d, err_d, core_rst_d;
    logic [ADDR_W-1:0] addr_d;
    logic [7:0]        data_d;

    // A preloaded memory never listens to the line
    assign rx_line = (PRELOAD != 0) ? 1'b1 : i_uart_rx;

    ice51_uart_rx #(
        .DIV(DIV)
    ) u_rx (
        .i_clk     (i_clk),
        .i_nrst    (i_nrst),
        .i_uart_rx (rx_line),
        .o_byte    (rx_byte),
        .o_valid   (rx_valid),
        .o_ferr    (rx_ferr)
    );

    // Loader state, counters and registered outputs
    always_ff @(posedge i_clk or posedge i_nrst) begin
        if (i_nrst) begin
            ld_state   <= LD_IMAGE;
            count      <= '0;
            sum        <= '0;
            o_mem_we   <= 1'b0;
            o_mem_addr <= '0;
            o_mem_data <= '0;
            o_core_rst <= 1'b1;
            o_done     <= 1'b0;
            o_err      <= 1'b0;
        end else begin
            ld_state   <= ld_state_d;
            count      <= count_d;
            sum        <= sum_d;
            o_mem_we   <= we_d;
            o_mem_addr <= addr_d;
            o_mem_data <= data_d;
            o_core_rst <= core_rst_d;
            o_done     <= done_d;
            o_err      <= err_d;
        end
    end

    // Image write, checksum compare and completion; core reset trails done by one cycle
    always_comb begin
        ld_state_d = ld_state;
        count_d    = count;
        sum_d      = sum;
        we_d       = 1'b0;
        addr_d     = o_mem_addr;
        data_d     = o_mem_data;
        done_d     = o_done;
        err_d      = o_err;
        core_rst_d = !o_done;
        if (PRELOAD != 0) begin
            ld_state_d = LD_DONE;
            done_d     = 1'b1;
            core_rst_d = 1'b0;
        end else begin
            if (rx_ferr) begin
                err_d = 1'b1;
            end
            case (ld_state)
                LD_IMAGE: begin
                    if (rx_valid) begin
                        we_d    = 1'b1;
                        addr_d  = count[ADDR_W-1:0];
                        data_d  = rx_byte;
                        count_d = count + CNT_W'(1);
                        sum_d   = sum + rx_byte;
                        if (count == LAST) begin
                            if (CHECKSUM != 0) begin
                                ld_state_d = LD_SUM;
                            end else begin
                                ld_state_d = LD_DONE;
                                done_d     = 1'b1;
                            end
                        end
                    end
                end
                LD_SUM: begin
                    if (rx_valid) begin
                        if (rx_byte == sum) begin
                            ld_state_d = LD_DONE;
                            done_d     = 1'b1;
                        end else begin
                            ld_state_d = LD_IMAGE;
                            err_d      = 1'b1;
                            count_d    = '0;
                            sum_d      = '0;
                        end
                    end
                end
                LD_DONE: ;
                default: ld_state_d = LD_IMAGE;
            endcase
        end
    end

endmodule

// File: tb/tb_ice51_uart_loader.sv
// Scoreboard bench: four loader configurations driven by serialised frames.
`timescale 1ns/1ps
module tb_ice51_uart_loader;

    localparam int N = 4;
    // 0: defaults, 4-byte image; 1: checksum; 2: preload; 3: MEM_SIZE = 2**ADDR_W
    localparam int DIVS [N] = '{104, 16, 16, 16};
    localparam int MEMS [N] = '{4, 4, 4, 8};
    localparam int CHKS [N] = '{0, 1, 0, 0};
    localparam int PRES [N] = '{0, 0, 1, 0};

    logic         clk;
    logic [N-1:0] rst, rx, we, done, err, crst;
    logic [8:0]   a0;
    logic [3:0]   a1, a2;
    logic [2:0]   a3;
    logic [8:0]   wa [N];
    logic [7:0]   wd [N];

    assign wa[0] = a0;
    assign wa[1] = 9'(a1);
    assign wa[2] = 9'(a2);
    assign wa[3] = 9'(a3);

    ice51_uart_loader #(.CLK_HZ(12000000), .BAUD(115200), .MEM_SIZE(4), .ADDR_W(9),
                        .CHECKSUM(0), .PRELOAD(0)) dut0 (
        .i_clk(clk), .i_nrst(rst[0]), .i_uart_rx(rx[0]), .o_mem_we(we[0]), .o_mem_addr(a0),
        .o_mem_data(wd[0]), .o_core_rst(crst[0]), .o_done(done[0]), .o_err(err[0]));
    ice51_uart_loader #(.CLK_HZ(1843200), .BAUD(115200), .MEM_SIZE(4), .ADDR_W(4),
                        .CHECKSUM(1), .PRELOAD(0)) dut1 (
        .i_clk(clk), .i_nrst(rst[1]), .i_uart_rx(rx[1]), .o_mem_we(we[1]), .o_mem_addr(a1),
        .o_mem_data(wd[1]), .o_core_rst(crst[1]), .o_done(done[1]), .o_err(err[1]));
    ice51_uart_loader #(.CLK_HZ(1843200), .BAUD(115200), .MEM_SIZE(4), .ADDR_W(4),
                        .CHECKSUM(0), .PRELOAD(1)) dut2 (
        .i_clk(clk), .i_nrst(rst[2]), .i_uart_rx(rx[2]), .o_mem_we(we[2]), .o_mem_addr(a2),
        .o_mem_data(wd[2]), .o_core_rst(crst[2]), .o_done(done[2]), .o_err(err[2]));
    ice51_uart_loader #(.CLK_HZ(1843200), .BAUD(115200), .MEM_SIZE(8), .ADDR_W(3),
                        .CHECKSUM(0), .PRELOAD(0)) dut3 (
        .i_clk(clk), .i_nrst(rst[3]), .i_uart_rx(rx[3]), .o_mem_we(we[3]), .o_mem_addr(a3),
        .o_mem_data(wd[3]), .o_core_rst(crst[3]), .o_done(done[3]), .o_err(err[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int dut;
        int addr;
        int data;
        bit done;
    } wr_t;

    wr_t exp_q [$];
    int  total = 0;
    int  bad   = 0;

    // Reference model of each loader
    int  m_cnt  [N];
    int  m_sum  [N];
    bit  m_done [N];
    bit  m_err  [N];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pop expected writes and watch the core-reset lag behind done
    logic [N-1:0] prev_done = '0;
    always @(negedge clk) begin
        for (int d = 0; d < N; d++) begin
            if (we[d]) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write dut%0d: got write addr=%0d data=%0h, expected none",
                             d, wa[d], wd[d]);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check($sformatf("write_dut d%0d", d), d, e.dut);
                    check($sformatf("write_addr d%0d", d), int'(wa[d]), e.addr);
                    check($sformatf("write_data d%0d", d), int'(wd[d]), e.data);
                    check($sformatf("done_with_write d%0d", d), int'(done[d]), int'(e.done));
                end
            end
            if (PRES[d] == 0) begin
                if (rst[d]) begin
                    prev_done[d] = 1'b0;
                end else begin
                    check($sformatf("core_rst_lag d%0d", d), int'(crst[d]), int'(!prev_done[d]));
                    prev_done[d] = done[d];
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic check_flags(input int d);
        @(negedge clk);
        check($sformatf("done d%0d", d), int'(done[d]), int'(m_done[d]));
        check($sformatf("err d%0d", d), int'(err[d]), int'(m_err[d]));
        if (PRES[d] != 0) check($sformatf("core_rst d%0d", d), int'(crst[d]), 0);
        tick(1);
    endtask

    task automatic do_reset(input int d);
        rst[d] = 1'b1;
        m_cnt[d] = 0; m_sum[d] = 0; m_done[d] = 1'b0; m_err[d] = 1'b0;
        tick(2);
        @(negedge clk);
        check($sformatf("rst_we d%0d", d), int'(we[d]), 0);
        check($sformatf("rst_done d%0d", d), int'(done[d]), 0);
        check($sformatf("rst_err d%0d", d), int'(err[d]), 0);
        check($sformatf("rst_core_rst d%0d", d), int'(crst[d]), 1);
        tick(1);
        rst[d] = 1'b0;
        tick(2);
    endtask

    // Model update from the loader's rules, then serialise the frame
    task automatic send_byte(input int d, input logic [7:0] b, input logic stop);
        int bp;
        bp = DIVS[d];
        if (PRES[d] == 0) begin
            if (!stop) begin
                m_err[d] = 1'b1;
            end else if (!m_done[d]) begin
                if (m_cnt[d] < MEMS[d]) begin
                    wr_t e;
                    e.dut  = d;
                    e.addr = m_cnt[d];
                    e.data = int'(b);
                    e.done = (CHKS[d] == 0) && (m_cnt[d] == MEMS[d] - 1);
                    exp_q.push_back(e);
                    if (e.done) m_done[d] = 1'b1;
                    m_sum[d] = (m_sum[d] + int'(b)) % 256;
                    m_cnt[d]++;
                end else if (int'(b) == m_sum[d]) begin
                    m_done[d] = 1'b1;
                end else begin
                    m_err[d] = 1'b1;
                    m_cnt[d] = 0;
                    m_sum[d] = 0;
                end
            end
        end
        rx[d] = 1'b0;
        tick(bp);
        for (int i = 0; i < 8; i++) begin
            rx[d] = b[i];
            tick(bp);
        end
        rx[d] = stop;
        tick(bp);
        rx[d] = 1'b1;
        tick(2 * bp);
        check_flags(d);
    endtask

    task automatic glitch(input int d, input int len);
        rx[d] = 1'b0;
        tick(len);
        rx[d] = 1'b1;
        tick(2 * DIVS[d]);
        check_flags(d);
    endtask

    initial begin
        logic [7:0] img [4];
        logic [7:0] b;
        rst = '1;
        rx  = '1;
        for (int d = 0; d < N; d++) begin
            m_cnt[d] = 0; m_sum[d] = 0; m_done[d] = 1'b0; m_err[d] = 1'b0;
        end
        tick(3);
        @(negedge clk);
        for (int d = 0; d < N; d++) begin
            check($sformatf("init_we d%0d", d), int'(we[d]), 0);
            check($sformatf("init_addr d%0d", d), int'(wa[d]), 0);
            check($sformatf("init_data d%0d", d), int'(wd[d]), 0);
            check($sformatf("init_done d%0d", d), int'(done[d]), 0);
            check($sformatf("init_err d%0d", d), int'(err[d]), 0);
            check($sformatf("init_core_rst d%0d", d), int'(crst[d]), 1);
        end
        tick(1);
        rst = '0;
        m_done[2] = 1'b1;
        // Preload: nothing before the first edge, done on it
        @(negedge clk);
        check("preload_before_edge_done", int'(done[2]), 0);
        check("preload_before_edge_core_rst", int'(crst[2]), 1);
        @(negedge clk);
        check("preload_first_edge_done", int'(done[2]), 1);
        check("preload_first_edge_core_rst", int'(crst[2]), 0);
        tick(1);

        // Basic 4-byte image at 115200 baud, then one ignored extra byte
        img = '{8'hA5, 8'h01, 8'hFF, 8'h3C};
        for (int i = 0; i < 4; i++) send_byte(0, img[i], 1'b1);
        send_byte(0, 8'($urandom), 1'b1);

        // Checksum: good image, framing error after done, bad sum then resend
        img = '{8'h10, 8'h20, 8'h30, 8'h40};
        for (int i = 0; i < 4; i++) send_byte(1, img[i], 1'b1);
        send_byte(1, 8'hA0, 1'b1);
        send_byte(1, 8'h55, 1'b0);
        do_reset(1);
        for (int i = 0; i < 4; i++) send_byte(1, img[i], 1'b1);
        send_byte(1, 8'hA1, 1'b1);
        for (int i = 0; i < 4; i++) send_byte(1, img[i], 1'b1);
        send_byte(1, 8'hA0, 1'b1);
        for (int r = 0; r < 3; r++) begin
            do_reset(1);
            for (int i = 0; i < 4; i++) send_byte(1, 8'($urandom), 1'b1);
            b = 8'(m_sum[1]);
            if ($urandom_range(0, 1) == 1) b = b ^ 8'(1 << $urandom_range(0, 7));
            send_byte(1, b, 1'b1);
            if (!m_done[1]) begin
                for (int i = 0; i < 4; i++) send_byte(1, 8'($urandom), 1'b1);
                send_byte(1, 8'(m_sum[1]), 1'b1);
            end
        end

        // Framing error then short glitch; the following image starts at address 0
        do_reset(0);
        send_byte(0, 8'h00, 1'b0);
        glitch(0, 20);
        for (int i = 0; i < 4; i++) send_byte(0, 8'($urandom), 1'b1);

        // Reset mid-load restarts from address 0
        do_reset(0);
        for (int i = 0; i < 2; i++) send_byte(0, 8'($urandom), 1'b1);
        do_reset(0);
        for (int i = 0; i < 4; i++) send_byte(0, 8'($urandom), 1'b1);

        // Preload ignores valid frames
        for (int i = 0; i < 3; i++) send_byte(2, 8'($urandom), 1'b1);

        // Full address space without wrap, ninth byte ignored, late framing error
        for (int i = 0; i < 8; i++) send_byte(3, 8'(i), 1'b1);
        send_byte(3, 8'($urandom), 1'b1);
        send_byte(3, 8'h00, 1'b0);

        tick(4);
        check("pending_writes", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
